// File: rtl/conv_pkg.sv
// Shared types for the streaming 3x3 convolution datapath: sequencer state
// encoding and the per-window image-edge flags consumed by the MAC stage.
package conv_pkg;

    localparam int KERNEL_DIM = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic top;
        logic bottom;
        logic left;
        logic right;
    } edge_t;

endpackage

// File: rtl/conv_pos_cnt.sv
// Raster (row,col) position counter against captured frame limits; col wraps
// at col_max_i and bumps row, row wraps at row_max_i.
module conv_pos_cnt #(
    parameter int WW = 11,
    parameter int HW = 11
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [WW-1:0] col_max_i,
    input  logic [HW-1:0] row_max_i,
    output logic [HW-1:0] row_o,
    output logic [WW-1:0] col_o,
    output logic          first_col_o,
    output logic          last_col_o,
    output logic          first_row_o,
    output logic          last_row_o
);

    logic [HW-1:0] row_q, row_d;
    logic [WW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == col_max_i) begin
                col_d = '0;
                row_d = (row_q == row_max_i) ? '0 : row_q + HW'(1);
            end else begin
                col_d = col_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign first_col_o = (col_q == '0);
    assign last_col_o  = (col_q == col_max_i);
    assign first_row_o = (row_q == '0);
    assign last_row_o  = (row_q == row_max_i);

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame scheduler for the 3x3 convolution: fills the line buffers, then emits
// one window event per pixel (in order, 1:1 with inputs) and drains at frame end.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter  int W_MAX = 1024,
    parameter  int H_MAX = 1024,
    localparam int WW    = $clog2(W_MAX + 1),
    localparam int HW    = $clog2(H_MAX + 1)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          start,
    input  logic [WW-1:0] cfg_width,
    input  logic [HW-1:0] cfg_height,
    output logic          busy,
    output logic          cfg_err,
    output logic          done,
    input  logic          in_vld,
    output logic          in_rdy,
    output logic          in_push,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [HW-1:0] out_row,
    output logic [WW-1:0] out_col,
    output logic [3:0]    out_edge
);

    function automatic logic cfg_ok(input logic [WW-1:0] w, input logic [HW-1:0] h);
        return (w >= WW'(2)) && (w <= WW'(W_MAX)) && (h >= HW'(2)) && (h <= HW'(H_MAX));
    endfunction

    seq_state_e    state_q, state_d;
    logic [WW-1:0] cfg_w_q, cfg_w_d;
    logic [HW-1:0] cfg_h_q, cfg_h_d;
    logic [WW-1:0] fill_q, fill_d;
    logic          cfg_err_q, cfg_err_d;
    logic          out_vld_q, out_vld_d;
    logic [HW-1:0] out_row_q, out_row_d;
    logic [WW-1:0] out_col_q, out_col_d;
    edge_t         out_edge_q, out_edge_d;

    logic          free, start_ok, in_last, last_shown, final_hs, out_adv;
    logic [WW-1:0] col_max;
    logic [HW-1:0] row_max;

    logic [HW-1:0] in_row_unused;
    logic [WW-1:0] in_col_unused;
    logic          in_first_row_unused, in_first_col_unused;
    logic          in_last_row, in_last_col;

    logic [HW-1:0] o_row;
    logic [WW-1:0] o_col;
    logic          o_first_row, o_last_row, o_first_col, o_last_col;

    assign col_max    = cfg_w_q - WW'(1);
    assign row_max    = cfg_h_q - HW'(1);
    assign free       = !out_vld_q || out_rdy;
    assign in_rdy     = (state_q == FILL) || ((state_q == RUN) && free);
    assign in_push    = in_vld && in_rdy;
    assign start_ok   = (state_q == IDLE) && start && cfg_ok(cfg_width, cfg_height);
    assign in_last    = in_last_row && in_last_col;
    // The bottom-right window is always the last one of the frame.
    assign last_shown = out_vld_q && out_edge_q.bottom && out_edge_q.right;
    assign final_hs   = (state_q == FLUSH) && last_shown && out_rdy;
    assign out_adv    = ((state_q == RUN) && in_push) ||
                        ((state_q == FLUSH) && free && !last_shown);

    conv_pos_cnt #(.WW(WW), .HW(HW)) u_in_pos (
        .clk         (clk),
        .arst        (arst),
        .clr_i       (start_ok),
        .inc_i       (in_push),
        .col_max_i   (col_max),
        .row_max_i   (row_max),
        .row_o       (in_row_unused),
        .col_o       (in_col_unused),
        .first_col_o (in_first_col_unused),
        .last_col_o  (in_last_col),
        .first_row_o (in_first_row_unused),
        .last_row_o  (in_last_row)
    );

    conv_pos_cnt #(.WW(WW), .HW(HW)) u_out_pos (
        .clk         (clk),
        .arst        (arst),
        .clr_i       (start_ok),
        .inc_i       (out_adv),
        .col_max_i   (col_max),
        .row_max_i   (row_max),
        .row_o       (o_row),
        .col_o       (o_col),
        .first_col_o (o_first_col),
        .last_col_o  (o_last_col),
        .first_row_o (o_first_row),
        .last_row_o  (o_last_row)
    );

    always_comb begin
        state_d   = state_q;
        cfg_w_d   = cfg_w_q;
        cfg_h_d   = cfg_h_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok(cfg_width, cfg_height)) begin
                        state_d = FILL;
                        cfg_w_d = cfg_width;
                        cfg_h_d = cfg_height;
                        fill_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            // One full row plus one pixel must be buffered before the first window.
            FILL: begin
                if (in_push) begin
                    if (fill_q == cfg_w_q) state_d = RUN;
                    else                   fill_d  = fill_q + WW'(1);
                end
            end
            RUN: begin
                if (in_push && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                if (final_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        out_edge_d = out_edge_q;
        if (out_adv) begin
            out_vld_d  = 1'b1;
            out_row_d  = o_row;
            out_col_d  = o_col;
            out_edge_d = '{top: o_first_row, bottom: o_last_row,
                           left: o_first_col, right: o_last_col};
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            cfg_w_q    <= '0;
            cfg_h_q    <= '0;
            fill_q     <= '0;
            cfg_err_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_edge_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_w_q    <= cfg_w_d;
            cfg_h_q    <= cfg_h_d;
            fill_q     <= fill_d;
            cfg_err_q  <= cfg_err_d;
            out_vld_q  <= out_vld_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_edge_q <= out_edge_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cfg_err  = cfg_err_q;
    assign done     = final_hs;
    assign out_vld  = out_vld_q;
    assign out_row  = out_row_q;
    assign out_col  = out_col_q;
    assign out_edge = out_edge_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: full-rate, stalled, minimum-size,
// bad-config, mid-frame reset and ignored-restart frames.
module tb_conv_window_sequencer;

    localparam int WW = 11;
    localparam int HW = 11;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] cfg_width = '0;
    logic [HW-1:0] cfg_height = '0;
    logic          busy, cfg_err, done;
    logic          in_vld = 1'b0;
    logic          in_rdy, in_push;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [HW-1:0] out_row;
    logic [WW-1:0] out_col;
    logic [3:0]    out_edge;

    int n_checks = 0;
    int n_errors = 0;

    conv_window_sequencer #(.W_MAX(1024), .H_MAX(1024)) dut (
        .clk        (clk),
        .arst       (arst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .done       (done),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_push    (in_push),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_edge   (out_edge)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    busy,     0);
        chk({tag, "_cfg_err"}, cfg_err,  0);
        chk({tag, "_done"},    done,     0);
        chk({tag, "_in_rdy"},  in_rdy,   0);
        chk({tag, "_in_push"}, in_push,  0);
        chk({tag, "_out_vld"}, out_vld,  0);
        chk({tag, "_out_row"}, out_row,  0);
        chk({tag, "_out_col"}, out_col,  0);
        chk({tag, "_out_edge"}, out_edge, 0);
    endtask

    // Runs one frame with in_vld held high; poke_at >= 0 pulses a 2x2 start
    // while that many inputs have been accepted.
    task automatic run_frame(input int w, input int h, input bit toggle, input int poke_at);
        int  acc = 0;
        int  win = 0;
        int  after_last = 0;
        int  first_cyc = -1;
        int  last_cyc = -1;
        bit  first_seen = 1'b0;
        bit  fin = 1'b0;
        int  r, c;
        logic [3:0] exp_edge;
        @(negedge clk);
        cfg_width  = WW'(w);
        cfg_height = HW'(h);
        start      = 1'b1;
        in_vld     = 1'b1;
        out_rdy    = 1'b1;
        #1 chk("idle_before_start", busy, 0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            start = (acc == poke_at);
            if (start) begin
                cfg_width  = WW'(2);
                cfg_height = HW'(2);
            end
            out_rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (cyc == 0) begin
                chk("busy_after_start", busy, 1);
                chk("no_cfg_err", cfg_err, 0);
            end
            r = win / w;
            c = win % w;
            exp_edge = {r == 0, r == h - 1, c == 0, c == w - 1};
            if (out_vld) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("first_win_latency", acc, w + 2);
                end
                chk("row", out_row, r);
                chk("col", out_col, c);
                chk("edge", out_edge, exp_edge);
            end
            if (out_vld && !out_rdy) chk("in_rdy_stall", in_rdy, 0);
            if (acc == w * h) chk("in_rdy_flush", in_rdy, 0);
            chk("in_push", in_push, in_vld & in_rdy);
            if (out_vld && out_rdy) begin
                chk("done", done, win == w * h - 1);
                if (acc == w * h) after_last++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                win++;
                if (win == w * h) fin = 1'b1;
            end else begin
                chk("done_quiet", done, 0);
            end
            if (in_vld && in_rdy) acc++;
        end
        start = 1'b0;
        chk("frame_done", fin, 1);
        chk("windows", win, w * h);
        chk("accepts", acc, w * h);
        if (!toggle) begin
            chk("throughput", last_cyc - first_cyc, w * h - 1);
            chk("tail_windows", after_last, w + 2);
        end
    endtask

    task automatic bad_start(input int w, input int h, input string tag);
        @(negedge clk);
        cfg_width  = WW'(w);
        cfg_height = HW'(h);
        start      = 1'b1;
        in_vld     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_cfg_err"}, cfg_err, 1);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_in_rdy"},  in_rdy,  0);
        @(negedge clk);
        #1;
        chk({tag, "_err_pulse"}, cfg_err, 0);
        chk({tag, "_busy2"},     busy,    0);
    endtask

    task automatic reset_mid_frame();
        int acc = 0;
        @(negedge clk);
        cfg_width  = WW'(4);
        cfg_height = HW'(3);
        start      = 1'b1;
        in_vld     = 1'b1;
        out_rdy    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && acc < 6; k++) begin
            #1;
            if (in_vld && in_rdy) acc++;
            @(negedge clk);
        end
        chk("rst_reached_7th", acc, 6);
        #1;
        chk("pre_rst_in_rdy",  in_rdy,  1);
        chk("pre_rst_out_vld", out_vld, 1);
        arst = 1'b1;
        #1;
        chk_all_zero("arst_mid");
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        #1 chk_all_zero("reset");
        arst = 1'b0;

        bad_start(1, 3, "w1");
        bad_start(4, 1025, "h_over");

        run_frame(4, 3, 1'b0, -1);
        run_frame(4, 3, 1'b1, -1);
        run_frame(2, 2, 1'b0, -1);

        reset_mid_frame();
        run_frame(4, 3, 1'b0, -1);

        run_frame(4, 3, 1'b0, 8);
        run_frame(2, 2, 1'b0, -1);

        @(negedge clk);
        in_vld = 1'b0;
        #1;
        chk("final_idle_busy", busy, 0);
        chk("final_idle_vld",  out_vld, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
